rptr_empty_lvl: RTL and testbench

Read-side pointer and status block for the asynchronous FIFO, parametrised in depth, with fill-level reporting, an almost-empty flag and sticky underflow detection. It sits in the read clock domain. It takes the write pointer (Gray, already two-flop synchronised into rclk) and produces:
- the binary RAM read address;
- the Gray read pointer sent to the write domain;
- registered status flags.

---
 rtl/fifo_ptr_pkg.sv | 35 +++
 rtl/rptr_empty_lvl_if.sv | 29 ++
 rtl/gray2bin.sv | 16 +
 rtl/rptr_empty_lvl.sv | 83 ++++++++
 tb/tb_rptr_empty_lvl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the asynchronous FIFO.
// Gray/binary conversion functions work on a fixed maximum width; callers
// zero-extend their operand and truncate the result to the width they need.
// params_ok() validates the read-side parameter pair at elaboration.
package fifo_ptr_pkg;

  localparam int unsigned MaxW = 32;

  function automatic logic [MaxW-1:0] bin2gray(input logic [MaxW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, limited to the low w bits.
  function automatic logic [MaxW-1:0] gray2bin(input logic [MaxW-1:0] g,
                                               input int unsigned   w);
    logic [MaxW-1:0] b;
    logic            acc;
    b   = '0;
    acc = 1'b0;
    for (int i = MaxW - 1; i >= 0; i--) begin
      if (i < int'(w)) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

  // Address width must be usable and the threshold must lie below the depth.
  function automatic bit params_ok(input int unsigned addrsize, input int unsigned thresh);
    return (addrsize >= 1) && (addrsize < 31) &&
           (longint'(thresh) < (longint'(1) << addrsize));
  endfunction

endpackage

// File: rtl/rptr_empty_lvl_if.sv
// Read-side FIFO status bus.
// master: the consumer (drives rinc, rclr_err) plus the synchroniser output
//         (rq2_wptr); observes address, pointer and status.
// slave:  the rptr_empty_lvl block.
interface rptr_empty_lvl_if #(
  parameter int unsigned ADDRSIZE = 4
);

  logic                rinc;
  logic                rclr_err;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                runderflow;

  modport master (
    output rinc, rclr_err, rq2_wptr,
    input  raddr, rptr, rempty, raempty, rlevel, runderflow
  );

  modport slave (
    input  rinc, rclr_err, rq2_wptr,
    output raddr, rptr, rempty, raempty, rlevel, runderflow
  );

endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of any width.
//   gray  input  WIDTH  Gray-coded value
//   bin   output WIDTH  binary equivalent
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray2bin #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side pointer and status block of the asynchronous FIFO (rclk domain).
//   rclk, rrst_n     read clock, asynchronous active-low reset
//   bus.rinc         pop request, ignored while rempty
//   bus.rclr_err     clears the sticky underflow flag
//   bus.rq2_wptr     Gray write pointer, already synchronised into rclk
//   bus.raddr        binary RAM read address (slice of rbin register)
//   bus.rptr         registered Gray read pointer for the write domain
//   bus.rempty       registered empty flag
//   bus.raempty      registered level <= AEMPTY_THRESH
//   bus.rlevel       registered words available, 0..2^ADDRSIZE
//   bus.runderflow   sticky: pop requested while empty
module rptr_empty_lvl
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned ADDRSIZE      = 4,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input logic             rclk,
  input logic             rrst_n,
  rptr_empty_lvl_if.slave bus
);

  localparam int unsigned      PtrW         = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AemptyThresh = PtrW'(AEMPTY_THRESH);

  if (!params_ok(ADDRSIZE, AEMPTY_THRESH)) begin : g_param_err
    $error("rptr_empty_lvl: need ADDRSIZE >= 1 and AEMPTY_THRESH < 2**ADDRSIZE");
  end

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rgray_d;
  logic [ADDRSIZE:0] rlevel_q, level_d;
  logic [ADDRSIZE:0] wbin_s;
  logic              rempty_q, rempty_d;
  logic              raempty_q, raempty_d;
  logic              runderflow_q, runderflow_d;
  logic              pop;

  gray2bin #(
    .WIDTH(PtrW)
  ) u_wptr_g2b (
    .gray(bus.rq2_wptr),
    .bin (wbin_s)
  );

  always_comb begin
    pop     = bus.rinc & ~rempty_q;
    rbin_d  = rbin_q + PtrW'(pop);
    rgray_d = PtrW'(bin2gray(MaxW'(rbin_d)));
    // Modulo subtraction stays correct across pointer wrap.
    level_d   = wbin_s - rbin_d;
    rempty_d  = (rgray_d == bus.rq2_wptr);
    raempty_d = (level_d <= AemptyThresh);
    // Set has priority over clear.
    runderflow_d = (bus.rinc & rempty_q) | (runderflow_q & ~bus.rclr_err);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rgray_d;
      rlevel_q     <= level_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign bus.raddr      = rbin_q[ADDRSIZE-1:0];
  assign bus.rptr       = rptr_q;
  assign bus.rlevel     = rlevel_q;
  assign bus.rempty     = rempty_q;
  assign bus.raempty    = raempty_q;
  assign bus.runderflow = runderflow_q;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Bench for rptr_empty_lvl: directed scenarios with literal expectations,
// then randomized pops/writes/clears checked every cycle against a
// counter-based model (read count, level, sticky flag).
module tb_rptr_empty_lvl;

  localparam int AW = 4;
  localparam int TH = 2;

  logic rclk     = 1'b0;
  logic rrst_n   = 1'b1;
  logic rinc     = 1'b0;
  logic rclr_err = 1'b0;
  int   wbin     = 0;

  rptr_empty_lvl_if #(.ADDRSIZE(AW)) bus ();

  assign bus.rinc     = rinc;
  assign bus.rclr_err = rclr_err;
  assign bus.rq2_wptr = 5'(wbin ^ (wbin >> 1));

  rptr_empty_lvl #(
    .ADDRSIZE     (AW),
    .AEMPTY_THRESH(TH)
  ) dut (
    .rclk  (rclk),
    .rrst_n(rrst_n),
    .bus   (bus)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: words read so far (mod 32), level as of the last edge, sticky flag.
  int m_rd    = 0;
  int m_level = 0;
  bit m_uflow = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rrst_n) begin
    m_rd    = 0;
    m_level = 0;
    m_uflow = 1'b0;
  end

  always @(posedge rclk) begin
    bit pop;
    if (rrst_n) begin
      pop = rinc && (m_level != 0);
      if (rinc && (m_level == 0)) m_uflow = 1'b1;
      else if (rclr_err)          m_uflow = 1'b0;
      m_rd    = (m_rd + int'(pop)) & 31;
      m_level = (wbin - m_rd) & 31;
    end
    #1;
    check("raddr", int'(bus.raddr), m_rd & 15);
    check("rptr", int'(bus.rptr), m_rd ^ (m_rd >> 1));
    check("rempty", int'(bus.rempty), int'(m_level == 0));
    check("raempty", int'(bus.raempty), int'(m_level <= TH));
    check("rlevel", int'(bus.rlevel), m_level);
    check("runderflow", int'(bus.runderflow), int'(m_uflow));
  end

  task automatic cyc();
    @(posedge rclk);
    #2;
  endtask

  initial begin
    int room;
    #1 rrst_n = 1'b0;
    #2;
    check("rst_rempty", int'(bus.rempty), 1);
    check("rst_raempty", int'(bus.raempty), 1);
    check("rst_rlevel", int'(bus.rlevel), 0);
    check("rst_rptr", int'(bus.rptr), 0);
    repeat (2) cyc();
    rrst_n = 1'b1;
    repeat (2) cyc();
    check("hold_rempty", int'(bus.rempty), 1);
    check("hold_rlevel", int'(bus.rlevel), 0);

    // Write visibility: Gray 00111 = 5 words.
    wbin = 5;
    cyc();
    check("wr_rempty", int'(bus.rempty), 0);
    check("wr_rlevel", int'(bus.rlevel), 5);
    check("wr_raempty", int'(bus.raempty), 0);

    // Pops down through the almost-empty threshold.
    rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("pop_rlevel", int'(bus.rlevel), 4 - i);
      check("pop_raddr", int'(bus.raddr), 1 + i);
      check("pop_raempty", int'(bus.raempty), int'(i == 2));
    end
    repeat (2) cyc();
    rinc = 1'b0;
    check("drain_rlevel", int'(bus.rlevel), 0);
    check("drain_rempty", int'(bus.rempty), 1);
    check("drain_rptr", int'(bus.rptr), 'b00111);

    // Underflow: set, hold, set-beats-clear, clear.
    rinc = 1'b1;
    cyc();
    rinc = 1'b0;
    check("uf_rptr", int'(bus.rptr), 'b00111);
    check("uf_set", int'(bus.runderflow), 1);
    cyc();
    check("uf_hold", int'(bus.runderflow), 1);
    rinc     = 1'b1;
    rclr_err = 1'b1;
    cyc();
    check("uf_setwins", int'(bus.runderflow), 1);
    check("uf_rptr2", int'(bus.rptr), 'b00111);
    rinc = 1'b0;
    cyc();
    rclr_err = 1'b0;
    check("uf_clear", int'(bus.runderflow), 0);

    // Walk the read pointer to 30, then wrap.
    wbin = 20;
    cyc();
    rinc = 1'b1;
    repeat (15) cyc();
    rinc = 1'b0;
    check("walk_raddr", int'(bus.raddr), 4);
    wbin = 30;
    cyc();
    rinc = 1'b1;
    repeat (10) cyc();
    rinc = 1'b0;
    check("wrap_rptr30", int'(bus.rptr), 'b10001);
    wbin = 2;
    cyc();
    check("wrap_rlevel", int'(bus.rlevel), 4);
    rinc = 1'b1;
    repeat (2) cyc();
    rinc = 1'b0;
    check("wrap_rptr0", int'(bus.rptr), 0);
    check("wrap_rlevel2", int'(bus.rlevel), 2);
    check("wrap_raempty", int'(bus.raempty), 1);

    // Full level, then pop with simultaneous write.
    wbin = 16;
    cyc();
    check("full_rlevel", int'(bus.rlevel), 16);
    check("full_rempty", int'(bus.rempty), 0);
    check("full_raempty", int'(bus.raempty), 0);
    rinc = 1'b1;
    wbin = 17;
    cyc();
    rinc = 1'b0;
    check("full_popwr", int'(bus.rlevel), 16);

    // Reset mid-traffic takes effect without a clock edge.
    rinc = 1'b1;
    cyc();
    #1 rrst_n = 1'b0;
    #1;
    check("mrst_rempty", int'(bus.rempty), 1);
    check("mrst_raempty", int'(bus.raempty), 1);
    check("mrst_rlevel", int'(bus.rlevel), 0);
    check("mrst_rptr", int'(bus.rptr), 0);
    check("mrst_raddr", int'(bus.raddr), 0);
    wbin = 0;
    rinc = 1'b0;
    cyc();
    rrst_n = 1'b1;
    repeat (2) cyc();
    check("mrst_hold", int'(bus.rempty), 1);

    // Randomized traffic; writes never push the level past 16.
    for (int n = 0; n < 3000; n++) begin
      rinc     = ($urandom_range(0, 99) < 55);
      rclr_err = ($urandom_range(0, 99) < 8);
      room     = 16 - ((wbin - m_rd) & 31);
      if ($urandom_range(0, 3) != 0)
        wbin = (wbin + int'($urandom_range(0, room))) & 31;
      if ($urandom_range(0, 999) == 0) begin
        #1 rrst_n = 1'b0;
        wbin = 0;
        rinc = 1'b0;
        #2 rrst_n = 1'b1;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
